// File: rtl/wb_hyperram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a HyperRAM controller, with slave-wait timeout abort.
// Latency: 1-cycle grant, combinational data path once granted; backpressure: losing master sees no ack until the bus is released.
module wb_hyperram_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic        timeout_o,
    input  logic        clr_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        last_gnt, last_gnt_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        abort_set;
    logic        req0, req1;
    logic        gnt_cyc, gnt_stb;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign gnt_cyc = (state == GNT1) ? m1_cyc_i : m0_cyc_i;
    assign gnt_stb = (state == GNT1) ? m1_stb_i : m0_stb_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            wait_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (abort_set) begin
                timeout_o <= 1'b1;
            end else if (clr_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        wait_cnt_nxt = wait_cnt;
        abort_set    = 1'b0;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_sel_o      = 4'h0;
        s_adr_o      = 32'h0;
        s_dat_o      = 32'h0;
        m0_ack_o     = 1'b0;
        m0_err_o     = 1'b0;
        m0_dat_o     = 32'h0;
        m1_ack_o     = 1'b0;
        m1_err_o     = 1'b0;
        m1_dat_o     = 32'h0;

        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (req0 && (!req1 || last_gnt)) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (state == GNT0) begin
                    s_cyc_o  = m0_cyc_i;
                    s_stb_o  = m0_stb_i;
                    s_we_o   = m0_we_i;
                    s_sel_o  = m0_sel_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    m0_ack_o = s_ack_i;
                    m0_dat_o = s_dat_i;
                end else begin
                    s_cyc_o  = m1_cyc_i;
                    s_stb_o  = m1_stb_i;
                    s_we_o   = m1_we_i;
                    s_sel_o  = m1_sel_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    m1_ack_o = s_ack_i;
                    m1_dat_o = s_dat_i;
                end
                if (!gnt_cyc) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = (state == GNT1);
                    wait_cnt_nxt = '0;
                end else if (s_ack_i) begin
                    wait_cnt_nxt = '0;
                end else if (gnt_stb) begin
                    if (wait_cnt == LAST_WAIT) begin
                        // last_gnt is updated on entry so ABORT can use it to pick the errored master
                        state_nxt    = ABORT;
                        last_gnt_nxt = (state == GNT1);
                        wait_cnt_nxt = '0;
                        abort_set    = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 16'd1;
                    end
                end
            end
            ABORT: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
                if (last_gnt) begin
                    m1_err_o = 1'b1;
                    m1_dat_o = ERR_DATA;
                end else begin
                    m0_err_o = 1'b1;
                    m0_dat_o = ERR_DATA;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked against a bus-ownership model of the arbiter.
module tb_wb_hyperram_arbiter;

    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       cyc, stb, we;
    logic [1:0][3:0]  sel;
    logic [1:0][31:0] adr, wdat;
    logic             s_ack, clr;
    logic [31:0]      s_rdat;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we, tmo;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;

    wb_hyperram_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .timeout_o(tmo), .clr_i(clr)
    );

    // Model: who owns the bus (-1 = nobody), pending abort, who wins the next tie, stalled strobes so far.
    int owner, abort_m, favored, stalls;
    bit aborting, sticky;
    int passed = 0, total = 0, failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; aborting = 0; abort_m = 0; favored = 0; stalls = 0; sticky = 0;
    endtask

    task automatic check_all();
        logic [31:0] e_cyc, e_stb, e_we, e_sel, e_adr, e_dat;
        logic [1:0][31:0] e_ack, e_err, e_rd;
        e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0; e_dat = 0;
        e_ack = '0; e_err = '0; e_rd = '0;
        if (owner >= 0) begin
            e_cyc = 32'(cyc[owner]); e_stb = 32'(stb[owner]); e_we = 32'(we[owner]);
            e_sel = 32'(sel[owner]); e_adr = adr[owner]; e_dat = wdat[owner];
            e_ack[owner] = 32'(s_ack); e_rd[owner] = s_rdat;
        end
        if (aborting) begin
            e_err[abort_m] = 1; e_rd[abort_m] = ERRD;
        end
        chk("s_cyc", 32'(s_cyc), e_cyc);
        chk("s_stb", 32'(s_stb), e_stb);
        chk("s_we", 32'(s_we), e_we);
        chk("s_sel", 32'(s_sel), e_sel);
        chk("s_adr", s_adr, e_adr);
        chk("s_dat", s_wdat, e_dat);
        chk("m0_ack", 32'(m0_ack), e_ack[0]);
        chk("m1_ack", 32'(m1_ack), e_ack[1]);
        chk("m0_err", 32'(m0_err), e_err[0]);
        chk("m1_err", 32'(m1_err), e_err[1]);
        chk("m0_dat", m0_rdat, e_rd[0]);
        chk("m1_dat", m1_rdat, e_rd[1]);
        chk("timeout", 32'(tmo), 32'(sticky));
    endtask

    task automatic model_edge();
        bit set_flag;
        set_flag = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (aborting) begin
            aborting = 0;
        end else if (owner < 0) begin
            if (cyc[0] && stb[0] && cyc[1] && stb[1]) owner = favored;
            else if (cyc[0] && stb[0]) owner = 0;
            else if (cyc[1] && stb[1]) owner = 1;
            stalls = 0;
        end else if (!cyc[owner]) begin
            favored = 1 - owner; owner = -1; stalls = 0;
        end else if (s_ack) begin
            stalls = 0;
        end else if (stb[owner]) begin
            stalls++;
            if (stalls == TO) begin
                aborting = 1; abort_m = owner; favored = 1 - owner;
                owner = -1; stalls = 0; set_flag = 1;
            end
        end
        if (set_flag) sticky = 1;
        else if (clr) sticky = 0;
    endtask

    // Inputs are driven at posedge+1; outputs are checked at posedge+2.
    task automatic cycle();
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; wdat = '0;
        s_ack = 0; s_rdat = 0; clr = 0; rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        cycle(); cycle();
        rst_n = 1;
        cycle();

        // Simultaneous requests twice: m0 then m1
        cyc = 2'b11; stb = 2'b11; we = 2'b00; sel[0] = 4'hF; sel[1] = 4'h3;
        adr[0] = $urandom; adr[1] = $urandom;
        cycle();
        chk("rr_first_adr", s_adr, adr[0]);
        s_ack = 1; s_rdat = $urandom; cycle();
        cyc = '0; stb = '0; s_ack = 0; cycle();
        cycle();
        cyc = 2'b11; stb = 2'b11; adr[0] = $urandom; adr[1] = $urandom;
        cycle();
        chk("rr_second_adr", s_adr, adr[1]);
        chk("rr_second_cyc", 32'(s_cyc), 1);
        s_ack = 1; cycle();
        cyc = '0; stb = '0; s_ack = 0; cycle(); cycle();

        // m0 single write, slave acks in the fourth cycle
        cyc[0] = 1; stb[0] = 1; we[0] = 1; sel[0] = 4'hF;
        adr[0] = 32'h30000010; wdat[0] = 32'h12345678;
        cycle();
        chk("wr_s_adr", s_adr, 32'h30000010);
        chk("wr_s_dat", s_wdat, 32'h12345678);
        chk("wr_s_we", 32'(s_we), 1);
        cycle(); cycle();
        s_ack = 1; #1;
        chk("wr_m0_ack", 32'(m0_ack), 1);
        chk("wr_m1_ack", 32'(m1_ack), 0);
        cycle();
        cyc = '0; stb = '0; we = '0; s_ack = 0; cycle(); cycle();

        // m1 bus lock over four reads while m0 waits
        cyc[1] = 1; stb[1] = 1; adr[1] = $urandom;
        cycle();
        cyc[0] = 1; stb[0] = 1; adr[0] = $urandom;
        for (int i = 0; i < 4; i++) begin
            s_ack = 1; s_rdat = $urandom; adr[1] = $urandom; #1;
            chk("lock_m1_dat", m1_rdat, s_rdat);
            chk("lock_m0_ack", 32'(m0_ack), 0);
            cycle();
        end
        cyc[1] = 0; stb[1] = 0; s_ack = 0;
        cycle();
        chk("lock_gap_s_cyc", 32'(s_cyc), 0);
        cycle();
        chk("lock_m0_gnt_adr", s_adr, adr[0]);
        s_ack = 1; cycle();
        cyc = '0; stb = '0; s_ack = 0; cycle(); cycle();

        // Timeout: slave never acks m0
        cyc[0] = 1; stb[0] = 1; s_ack = 0;
        repeat (9) cycle();
        chk("abort_err", 32'(m0_err), 1);
        chk("abort_dat", m0_rdat, 32'hDEADBEEF);
        chk("abort_s_cyc", 32'(s_cyc), 0);
        chk("abort_tmo", 32'(tmo), 1);
        s_ack = 1; cyc[0] = 0; stb[0] = 0; #1;
        chk("abort_ack_ignored", 32'(m0_ack), 0);
        cycle();
        chk("idle_ack_m0", 32'(m0_ack), 0);
        chk("idle_ack_m1", 32'(m1_ack), 0);
        s_ack = 0;
        repeat (3) cycle();
        chk("tmo_sticky", 32'(tmo), 1);
        clr = 1; cycle();
        clr = 0;
        chk("tmo_cleared", 32'(tmo), 0);
        cycle();

        // Asynchronous reset while m1 owns the bus
        cyc[1] = 1; stb[1] = 1; adr[1] = $urandom;
        cycle();
        s_ack = 1; s_rdat = $urandom; #1;
        chk("pre_rst_m1_ack", 32'(m1_ack), 1);
        chk("pre_rst_s_cyc", 32'(s_cyc), 1);
        rst_n = 0; #1;
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_m1_ack", 32'(m1_ack), 0);
        chk("rst_m1_dat", m1_rdat, 0);
        model_reset();
        @(posedge clk); #1;
        cyc = 2'b11; stb = 2'b11; adr[0] = $urandom; adr[1] = $urandom; s_ack = 0;
        cycle();
        rst_n = 1;
        cycle();
        chk("rst_rr_adr", s_adr, adr[0]);
        s_ack = 1; cycle();
        cyc = '0; stb = '0; s_ack = 0; cycle(); cycle();

        // Randomized traffic: responsive slave, then a mostly-stalling slave
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                for (int m = 0; m < 2; m++) begin
                    if ($urandom_range(9) == 0) cyc[m] = ~cyc[m];
                    stb[m]  = cyc[m] ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
                    we[m]   = 1'($urandom);
                    sel[m]  = 4'($urandom);
                    adr[m]  = $urandom;
                    wdat[m] = $urandom;
                end
                s_ack  = (ph == 0) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
                s_rdat = $urandom;
                clr    = ($urandom_range(29) == 0);
                cycle();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
